dot_product_engine: RTL and testbench
=====================================

DOT_PRODUCT_ENGINE -- requirements
Module: dot_product_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, signed operand width.
REQ-002 SHALL have parameter ACC_W, default 16, signed accumulator and result width.
REQ-003 SHALL have parameter K_LEN, default 9, operand pairs per dot product (3x3 kernel); legal range 1..255.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, operand pair present.
REQ-007 SHALL have port in_ready, output, 1, engine accepts an operand pair this cycle.
REQ-008 SHALL have port a, input, DATA_W, signed activation operand.
REQ-009 SHALL have port b, input, DATA_W, signed weight operand.
REQ-010 SHALL have port out_valid, output, 1, result present.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-012 SHALL have port out_data, output, ACC_W, signed dot-product result.
REQ-013 SHALL have port out_ovf, output, 1, sticky overflow flag for the current result.
REQ-014 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-015 SHALL accept a beat only when in_valid and in_ready are both high in the same cycle.
REQ-016 SHALL implement states IDLE, ACCUM and HOLD.
REQ-017 IDLE: in_ready=1; an accepted beat loads acc = a*b and count = 1, then goes to ACCUM, or to HOLD if K_LEN=1.
REQ-018 ACCUM: in_ready=1; an accepted beat does acc = acc + a*b and count + 1; the beat making count = K_LEN goes to HOLD; cycles without a beat hold all state.
REQ-019 HOLD: in_ready=0, out_valid=1, out_data=acc; when out_ready=1, go to IDLE and drop out_valid on the next edge.
REQ-020 out_valid SHALL rise on the edge that accepts the K_LEN-th beat, with zero bubble cycles.
REQ-021 The product SHALL be the full signed 2*DATA_W-bit value, sign-extended to ACC_W before addition.
REQ-022 Accumulation SHALL wrap modulo 2^ACC_W in two's complement.
REQ-023 out_ovf SHALL set when any addition's true result lies outside the ACC_W signed range, stay set until the result is consumed, and clear on the first beat of the next dot product.
REQ-024 out_data and out_ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 in_valid during HOLD SHALL be ignored, and the beat SHALL NOT be consumed.
REQ-026 Back-to-back dot products SHALL be accepted, with the next first beat taken one cycle after the handshake.
REQ-027 The count register SHALL be 8 bits wide and SHALL never exceed K_LEN.

Reset
REQ-028 Assertion of rst SHALL immediately force state=IDLE, acc=0, count=0, out_ovf=0, out_valid=0 and in_ready=1 (because state is IDLE), regardless of clock.
REQ-029 A partial dot product interrupted by rst SHALL be discarded; no result is emitted for it.
REQ-030 The first beat SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-031 Shared package SHALL hold the state enumeration (IDLE/ACCUM/HOLD) and the default DATA_W, ACC_W and K_LEN constants.
REQ-032 The multiply stage SHALL be one sub-module, mult_signed (DATA_W x DATA_W -> 2*DATA_W, combinational); the FSM, accumulator and handshake SHALL live in dot_product_engine.

Verification
REQ-033 With K_LEN=3, beats (2,3),(1,4),(-1,5), out_ready=1 -> out_valid for exactly 1 cycle, out_data=5, out_ovf=0, aligned with the third accept.
REQ-034 With K_LEN=3, in_valid toggling 1,0,1,0,1 -> result out_data=5, only 3 accepts counted, no early out_valid.
REQ-035 With K_LEN=3 and out_ready=0 for 4 cycles after completion -> out_valid held, out_data=5 stable, in_ready=0, no beats consumed; release -> handshake, then IDLE.
REQ-036 With K_LEN=9, nine beats of (-128,-128) -> true sum 147456 overflows; out_ovf=1, out_data=147456 mod 65536 = 16384; the next vector yields out_ovf=0.
REQ-037 With K_LEN=3, rst asserted asynchronously mid-cycle after 2 beats -> outputs go to reset values immediately; a fresh vector (1,1)x3 then yields out_data=3.
REQ-038 With K_LEN=1, continuous beats with out_ready=1 -> one result every 2 cycles, out_data=a*b each time.

Source files
------------

// File: rtl/dot_product_engine_pkg.sv
// Shared definitions for the dot-product engine: controller states and the
// default operand, accumulator and kernel-length sizes.
package dot_product_engine_pkg;

  localparam int DPE_DATA_W = 8;
  localparam int DPE_ACC_W  = 16;
  localparam int DPE_K_LEN  = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/dot_product_engine_mult_signed.sv
// Combinational signed multiplier producing the full-width product.
module mult_signed #(
  parameter int DATA_W = 8
) (
  input  logic signed [DATA_W-1:0]   a_i,
  input  logic signed [DATA_W-1:0]   b_i,
  output logic signed [2*DATA_W-1:0] p_o
);

  // Widen both operands first so the multiply is evaluated at full product width.
  assign p_o = (2*DATA_W)'(a_i) * (2*DATA_W)'(b_i);

endmodule

// File: rtl/dot_product_engine.sv
// Streaming signed dot-product engine: accumulates K_LEN products, then holds
// the result (with a sticky overflow flag) until downstream takes it.
//
// state | meaning
// IDLE  | waiting for the first operand pair of a new dot product
// ACCUM | partial sum in progress, count beats taken so far
// HOLD  | result presented on out_data, waiting for out_ready
module dot_product_engine
  import dot_product_engine_pkg::*;
#(
  parameter int DATA_W = DPE_DATA_W,
  parameter int ACC_W  = DPE_ACC_W,
  parameter int K_LEN  = DPE_K_LEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     out_ovf,
  output logic                     busy
);

  localparam logic [7:0] LAST_CNT = 8'(K_LEN - 1);

  state_e                     state_q, state_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [7:0]                 count_q, count_d;
  logic                       ovf_q, ovf_d;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W:0]      sum_wide;
  logic                       add_ovf;

  mult_signed #(.DATA_W(DATA_W)) u_mult (
    .a_i (a),
    .b_i (b),
    .p_o (prod)
  );

  assign prod_ext = ACC_W'(prod);
  // One guard bit: a signed overflow shows up as the top two bits disagreeing.
  assign sum_wide = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod_ext);
  assign add_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = prod_ext;
          count_d = 8'd1;
          ovf_d   = 1'b0;
          state_d = (K_LEN == 1) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d   = sum_wide[ACC_W-1:0];
          count_d = count_q + 8'd1;
          ovf_d   = ovf_q | add_ovf;
          if (count_q == LAST_CNT) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_dot_product_engine.sv
// Bench for dot_product_engine: three instances (K_LEN 3, 9, 1) checked every
// cycle against an arithmetic model, plus directed cases with literal results.
module tb_dot_product_engine;

  logic              clk;
  logic              rst;
  logic              iv   [3];
  logic              ir   [3];
  logic signed [7:0] a_s  [3];
  logic signed [7:0] b_s  [3];
  logic              ov   [3];
  logic              ordy [3];
  logic signed [15:0] od  [3];
  logic              oovf [3];
  logic              bsy  [3];

  int klen [3] = '{3, 9, 1};

  int checks   = 0;
  int failures = 0;

  // Model state: beats taken in the current vector, wrapped sum, sticky flag,
  // and whether a finished result is waiting for its handshake.
  int     n_m    [3];
  longint acc_m  [3];
  bit     ovf_m  [3];
  bit     hold_m [3];

  dot_product_engine #(.DATA_W(8), .ACC_W(16), .K_LEN(3)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_s[0]), .b(b_s[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_ovf(oovf[0]), .busy(bsy[0]));

  dot_product_engine #(.DATA_W(8), .ACC_W(16), .K_LEN(9)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_s[1]), .b(b_s[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_ovf(oovf[1]), .busy(bsy[1]));

  dot_product_engine #(.DATA_W(8), .ACC_W(16), .K_LEN(1)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_s[2]), .b(b_s[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .out_ovf(oovf[2]), .busy(bsy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int inst, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s inst%0d got=%0d expected=%0d t=%0t", name, inst, got, exp, $time);
    end
  endtask

  function automatic longint wrap16(input longint x);
    longint r;
    r = x & 64'hFFFF;
    if (r >= 32768) r = r - 65536;
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) begin
      n_m[i] = 0; acc_m[i] = 0; ovf_m[i] = 0; hold_m[i] = 0;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < 3; i++) begin
          n_m[i] = 0; acc_m[i] = 0; ovf_m[i] = 0; hold_m[i] = 0;
        end
      end else begin
        for (int i = 0; i < 3; i++) begin
          longint p, t;
          if (hold_m[i]) begin
            if (ordy[i]) hold_m[i] = 0;
          end else if (iv[i]) begin
            p = longint'(a_s[i]) * longint'(b_s[i]);
            if (n_m[i] == 0) begin
              acc_m[i] = p;
              ovf_m[i] = 0;
            end else begin
              t = acc_m[i] + p;
              if (t > 32767 || t < -32768) ovf_m[i] = 1;
              acc_m[i] = wrap16(t);
            end
            n_m[i]++;
            if (n_m[i] == klen[i]) begin
              hold_m[i] = 1;
              n_m[i] = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk("out_valid", i, ov[i], hold_m[i]);
        chk("in_ready", i, ir[i], !hold_m[i]);
        chk("busy", i, bsy[i], hold_m[i] || n_m[i] != 0);
        if (hold_m[i]) begin
          chk("out_data", i, od[i], acc_m[i]);
          chk("out_ovf", i, oovf[i], ovf_m[i]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int i, input int av, input int bv);
    iv[i] = 1'b1;
    a_s[i] = 8'(av);
    b_s[i] = 8'(bv);
    step();
    iv[i] = 1'b0;
  endtask

  initial begin
    int pulses;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; a_s[i] = '0; b_s[i] = '0; ordy[i] = 1'b1;
    end
    #1;
    chk("rst_out_valid", 0, ov[0], 0);
    chk("rst_in_ready", 0, ir[0], 1);
    chk("rst_out_data", 0, od[0], 0);
    step(); step();
    rst = 1'b0;
    step();

    // Basic vector, result visible right after the third accept, for one cycle
    beat(0, 2, 3); beat(0, 1, 4);
    chk("early_valid", 0, ov[0], 0);
    beat(0, -1, 5);
    chk("basic_valid", 0, ov[0], 1);
    chk("basic_data", 0, od[0], 5);
    chk("basic_ovf", 0, oovf[0], 0);
    step();
    chk("basic_drop", 0, ov[0], 0);

    // in_valid toggling 1,0,1,0,1
    beat(0, 2, 3); step(); beat(0, 1, 4); step();
    chk("toggle_early", 0, ov[0], 0);
    beat(0, -1, 5);
    chk("toggle_valid", 0, ov[0], 1);
    chk("toggle_data", 0, od[0], 5);
    step();

    // Back-pressure: result stable, beats offered during HOLD not consumed
    ordy[0] = 1'b0;
    beat(0, 2, 3); beat(0, 1, 4); beat(0, -1, 5);
    for (int c = 0; c < 4; c++) begin
      iv[0] = 1'b1; a_s[0] = 8'sd7; b_s[0] = 8'sd7;
      step();
      chk("hold_valid", 0, ov[0], 1);
      chk("hold_data", 0, od[0], 5);
      chk("hold_ready", 0, ir[0], 0);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    step();
    chk("release_idle", 0, bsy[0], 0);
    beat(0, 1, 1); beat(0, 1, 1); beat(0, 1, 1);
    chk("after_hold_data", 0, od[0], 3);
    step();

    // Overflow on K_LEN=9, then cleared by the next vector
    for (int k = 0; k < 9; k++) beat(1, -128, -128);
    chk("ovf_valid", 1, ov[1], 1);
    chk("ovf_data", 1, od[1], 16384);
    chk("ovf_flag", 1, oovf[1], 1);
    step();
    for (int k = 0; k < 9; k++) beat(1, 1, 1);
    chk("ovf_clear_data", 1, od[1], 9);
    chk("ovf_clear_flag", 1, oovf[1], 0);
    step();

    // Async reset mid-cycle after two beats
    beat(0, 5, 5); beat(0, 6, 6);
    #2;
    rst = 1'b1;
    #1;
    chk("async_busy", 0, bsy[0], 0);
    chk("async_data", 0, od[0], 0);
    chk("async_ready", 0, ir[0], 1);
    #1;
    rst = 1'b0;
    beat(0, 1, 1);
    chk("first_after_rst", 0, bsy[0], 1);
    beat(0, 1, 1); beat(0, 1, 1);
    chk("fresh_valid", 0, ov[0], 1);
    chk("fresh_data", 0, od[0], 3);
    step();

    // K_LEN=1 continuous beats: one result every two cycles
    pulses = 0;
    iv[2] = 1'b1; a_s[2] = -8'sd7; b_s[2] = 8'sd9;
    step();
    chk("k1_data", 2, od[2], -63);
    if (ov[2]) pulses++;
    for (int c = 1; c < 20; c++) begin
      a_s[2] = 8'($urandom); b_s[2] = 8'($urandom);
      step();
      if (ov[2]) pulses++;
    end
    iv[2] = 1'b0;
    chk("k1_rate", 2, pulses, 10);
    step();

    // Randomized traffic on all instances, with one async reset in the middle
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        iv[i]   = ($urandom_range(0, 9) < 7);
        ordy[i] = ($urandom_range(0, 9) < 6);
        if (i == 1 && $urandom_range(0, 1) == 1) begin
          a_s[i] = $urandom_range(0, 1) ? -8'sd128 : 8'sd127;
          b_s[i] = $urandom_range(0, 1) ? -8'sd128 : 8'sd127;
        end else begin
          a_s[i] = 8'($urandom);
          b_s[i] = 8'($urandom);
        end
      end
      if (c == 1500) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1;
    end
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
